invntt_ctrl: RTL and testbench
==============================

Name: invntt_ctrl

Overview:
Sequencer for the inverse-NTT butterfly datapath (invntt_cal) over one 256-coefficient Kyber polynomial held in a dual-port coefficient RAM.
- Generates read addresses (j, j+len) and the zeta ROM index.
- Selects the final-stage scaling constant.
- Delays addresses to produce aligned write-backs.
- Runs all 7 Gentleman-Sande stages (len = 2..128) from one start pulse.

Parameters:
RD_LAT, 1, read latency of coefficient RAM and zeta ROM (cycles from address to data at butterfly input)
CAL_LAT, 2, butterfly pipeline latency (operands in to r1/r2 valid)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to begin a transform; sampled only in IDLE
busy  out  1  high from cycle after accepted start until done
done  out  1  1-cycle pulse after final write-back
cal_en  out  1  enable to butterfly pipeline (drives its set input); equals busy
rd_en  out  1  coefficient RAM read strobe
rd_addr_j  out  8  address of f[j]
rd_addr_jl  out  8  address of f[j+len]
zeta_idx  out  7  zeta ROM index k, valid with rd_en
last_stage  out  1  high when butterfly operands belong to stage 6; delayed RD_LAT from issue; selects zeta2 = 1441 (else -1044)
wr_en  out  1  write-back strobe for r2→addr_j, r1→addr_jl
wr_addr_j  out  8  write address for r2
wr_addr_jl  out  8  write address for r1

Behaviour:
- Define PIPE = RD_LAT + CAL_LAT.
- Reset (async, rst_n=0): state IDLE; stage s=0; butterfly counter b=0.
  - All outputs 0.
  - Write-pipeline valid bits cleared; no wr_en after reset release.
  - Reset mid-transform aborts immediately; RAM contents are then undefined.
- FSM IDLE → ISSUE → DRAIN → (ISSUE | FIN) → IDLE.
  - IDLE: start=1 → ISSUE next cycle, busy=1, s=0, b=0.
  - ISSUE: rd_en=1 every cycle, b increments 0..127. After b=127 → DRAIN.
  - DRAIN: rd_en=0 for exactly PIPE cycles. If s<6: s++, b=0, → ISSUE. Else → FIN.
  - FIN: one cycle; done=1, busy→0, → IDLE.
- Address generation, with len = 2^(s+1), g = b>>(s+1), m = b & (len-1):
  - j = g·2·len + m.
  - rd_addr_j = j; rd_addr_jl = j + len (never exceeds 255).
  - zeta_idx = (128>>s) - 1 - g. This equals 127 down to 64 in stage 0 and 1 in stage 6, so k decrements monotonically across the whole transform and index 0 is never issued.
- Write pipeline: shift register of depth PIPE carrying {valid, addr_j, addr_jl}.
  - wr_en and wr_addr_* equal rd_en and rd_addr_* delayed exactly PIPE cycles.
  - last_stage = (s==6) delayed RD_LAT.
- Stage hazard: first read of stage s+1 occurs one cycle after last write of stage s; the RAM is write-first-then-read across cycles.
  - Within a stage each index is touched once, so there are no hazards.
- Timing, with start sampled at edge 0:
  - Stage s reads at cycles 1+s·(128+PIPE) through 128+s·(128+PIPE).
  - Last wr_en at 7·(128+PIPE)-1+1 = 917 for defaults.
  - done at 918.
  - 896 total wr_en pulses.
- start while busy or in FIN: ignored, with no restart and no queuing.
- start held high continuously: a new transform begins each time IDLE is re-entered.

Test Plan:
- Reset, pulse start, count cycles → busy rises at cycle 1; exactly 896 rd_en and 896 wr_en; done single pulse at cycle 918; busy low at 919.
- Stage 0 first issues → (j, j+len, k) = (0,2,127), (1,3,127), (4,6,126); at b=127: (253,255,64). Stage 6 b=0 → (0,128,1); b=127 → (127,255,1) with last_stage=1 one cycle later.
- Alignment: every wr_en cycle t matches rd_en at t-3 with identical addresses. Confirm stage 1 first rd_en (cycle 132) is one cycle after stage 0 last wr_en (cycle 131).
- Pulse start at cycles 50 and 500 during run → no effect; done still at 918 with no second run.
- Assert rst_n=0 at cycle 300 for 2 cycles → all outputs 0 immediately, including pending wr_en; after release, outputs stay idle until a new start, which produces a full 918-cycle run.
- End-to-end with invntt_cal, RAM, and ROM: load NTT-domain random polynomial → RAM matches the golden Kyber invntt output (Montgomery-scaled, coefficients reduced mod 3329) for 3 seeds plus all-zero → all-zero.

Source files
------------

// File: rtl/invntt_ctrl.sv
// Inverse-NTT sequencer: walks 7 Gentleman-Sande stages over 256 coefficients,
// issuing butterfly reads and aligned write-backs.
module invntt_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int CAL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       cal_en,
  output logic       rd_en,
  output logic [7:0] rd_addr_j,
  output logic [7:0] rd_addr_jl,
  output logic [6:0] zeta_idx,
  output logic       last_stage,
  output logic       wr_en,
  output logic [7:0] wr_addr_j,
  output logic [7:0] wr_addr_jl
);

  localparam int PIPE = RD_LAT + CAL_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t     state;
  logic [2:0] s;
  logic [6:0] b;
  logic [7:0] cnt;

  // {j, j+len, k} for butterfly b of stage st
  function automatic logic [22:0] gen(
    input logic [2:0] st,
    input logic [6:0] bi
  );
    logic [3:0] sh;
    logic [7:0] mask;
    logic [6:0] g;
    logic [7:0] j8;
    logic [7:0] len8;
    logic [6:0] k7;
    sh   = {1'b0, st} + 4'd1;
    mask = (8'd1 << sh) - 8'd1;
    g    = bi >> sh;
    len8 = 8'd1 << sh;
    j8   = ({1'b0, g} << (sh + 4'd1)) | ({1'b0, bi} & mask);
    k7   = 7'((8'd128 >> st) - 8'd1) - g;
    return {j8, j8 + len8, k7};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= '0;
      b          <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr_j  <= '0;
      rd_addr_jl <= '0;
      zeta_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            busy  <= 1'b1;
            s     <= '0;
            b     <= '0;
            rd_en <= 1'b1;
            {rd_addr_j, rd_addr_jl, zeta_idx} <= gen(3'd0, 7'd0);
          end
        end
        ISSUE: begin
          if (b == 7'd127) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            cnt   <= '0;
          end else begin
            b <= b + 7'd1;
            {rd_addr_j, rd_addr_jl, zeta_idx} <= gen(s, b + 7'd1);
          end
        end
        DRAIN: begin
          if (cnt == 8'(PIPE - 1)) begin
            if (s == 3'd6) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              s     <= s + 3'd1;
              b     <= '0;
              rd_en <= 1'b1;
              {rd_addr_j, rd_addr_jl, zeta_idx} <= gen(s + 3'd1, 7'd0);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cal_en = busy;

  logic [PIPE-1:0]   vp;
  logic [7:0]        pj  [PIPE];
  logic [7:0]        pjl [PIPE];
  logic [RD_LAT-1:0] lp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp <= '0;
      lp <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pj[i]  <= '0;
        pjl[i] <= '0;
      end
    end else begin
      vp[0]  <= rd_en;
      pj[0]  <= rd_addr_j;
      pjl[0] <= rd_addr_jl;
      for (int i = 1; i < PIPE; i++) begin
        vp[i]  <= vp[i-1];
        pj[i]  <= pj[i-1];
        pjl[i] <= pjl[i-1];
      end
      lp[0] <= rd_en & (s == 3'd6);
      for (int i = 1; i < RD_LAT; i++) lp[i] <= lp[i-1];
    end
  end

  assign wr_en      = vp[PIPE-1];
  assign wr_addr_j  = pj[PIPE-1];
  assign wr_addr_jl = pjl[PIPE-1];
  assign last_stage = lp[RD_LAT-1];

endmodule

// File: tb/tb_invntt_ctrl.sv
// Bench for invntt_ctrl: cycle trace from a loop-nest model of the
// Kyber inverse NTT plus table vectors and multi-cycle corner sequences.
module tb_invntt_ctrl;

  localparam int RD_LAT  = 1;
  localparam int CAL_LAT = 2;
  localparam int PIPE    = RD_LAT + CAL_LAT;
  localparam int NC      = 1000;

  logic       clk, rst_n, start;
  logic       busy, done, cal_en, rd_en, last_stage, wr_en;
  logic [7:0] rd_addr_j, rd_addr_jl, wr_addr_j, wr_addr_jl;
  logic [6:0] zeta_idx;

  invntt_ctrl #(.RD_LAT(RD_LAT), .CAL_LAT(CAL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .cal_en(cal_en),
    .rd_en(rd_en), .rd_addr_j(rd_addr_j), .rd_addr_jl(rd_addr_jl),
    .zeta_idx(zeta_idx), .last_stage(last_stage),
    .wr_en(wr_en), .wr_addr_j(wr_addr_j), .wr_addr_jl(wr_addr_jl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       e_rd[NC], e_wr[NC], e_last[NC], e_busy[NC], e_done[NC];
  logic [7:0] e_j[NC], e_jl[NC], e_wj[NC], e_wjl[NC];
  logic [6:0] e_k[NC];
  int         done_cyc;

  logic       o_rd[NC], o_wr[NC], o_last[NC], o_busy[NC];
  logic [7:0] o_j[NC], o_jl[NC];
  logic [6:0] o_k[NC];
  int         rd_cnt, wr_cnt, done_cnt, done_at;

  typedef struct {
    int cyc;
    int j;
    int jl;
    int k;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Trace straight from the textbook loop nest: len doubles, k counts down.
  function automatic void build_model();
    int t, k, s;
    t = 0;
    k = 127;
    s = 0;
    for (int c = 0; c < NC; c++) begin
      e_rd[c] = 0; e_wr[c] = 0; e_last[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_j[c] = 0; e_jl[c] = 0; e_wj[c] = 0; e_wjl[c] = 0; e_k[c] = 0;
    end
    for (int len = 2; len <= 128; len *= 2) begin
      int n;
      n = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          t = 1 + s * (128 + PIPE) + n;
          e_rd[t] = 1;
          e_j[t] = 8'(j);
          e_jl[t] = 8'(j + len);
          e_k[t] = 7'(k);
          e_wr[t+PIPE] = 1;
          e_wj[t+PIPE] = 8'(j);
          e_wjl[t+PIPE] = 8'(j + len);
          if (len == 128) e_last[t+RD_LAT] = 1;
          n++;
        end
        k--;
      end
      s++;
    end
    done_cyc = t + PIPE + 1;
    for (int c = 1; c <= done_cyc; c++) e_busy[c] = 1;
    e_done[done_cyc] = 1;
  endfunction

  // Starts a transform, then compares every cycle against the model.
  task automatic run(input int ncyc, input int p1, input int p2, input int p3);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < NC; c++) begin
      o_rd[c] = 0; o_wr[c] = 0; o_last[c] = 0; o_busy[c] = 0;
      o_j[c] = 0; o_jl[c] = 0; o_k[c] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == p1 || c == p2 || c == p3);
      o_rd[c] = rd_en; o_wr[c] = wr_en; o_last[c] = last_stage;
      o_busy[c] = busy; o_j[c] = rd_addr_j; o_jl[c] = rd_addr_jl;
      o_k[c] = zeta_idx;
      if (rd_en) rd_cnt++;
      if (wr_en) wr_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      chk("ctl", c, {26'd0, busy, cal_en, done, rd_en, last_stage, wr_en},
          {26'd0, e_busy[c], e_busy[c], e_done[c], e_rd[c], e_last[c], e_wr[c]});
      if (e_rd[c])
        chk("rdaddr", c, {9'd0, rd_addr_j, rd_addr_jl, zeta_idx},
            {9'd0, e_j[c], e_jl[c], e_k[c]});
      if (e_wr[c])
        chk("wraddr", c, {16'd0, wr_addr_j, wr_addr_jl},
            {16'd0, e_wj[c], e_wjl[c]});
    end
    start = 1'b0;
  endtask

  task automatic check_idle(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk(name, c, {16'd0, busy, cal_en, done, rd_en, last_stage, wr_en,
                    rd_addr_j, 2'd0},
          32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{1, 0, 2, 127};
    tbl[1] = '{2, 1, 3, 127};
    tbl[2] = '{3, 4, 6, 126};
    tbl[3] = '{128, 253, 255, 64};
    tbl[4] = '{787, 0, 128, 1};
    tbl[5] = '{914, 127, 255, 1};

    build_model();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", 0,
        {busy, cal_en, done, rd_en, last_stage, wr_en, wr_addr_j, wr_addr_jl,
         rd_addr_j, 2'd0},
        32'd0);
    rst_n = 1'b1;
    check_idle(4, "idle_after_reset");

    run(930, 50, 500, int'($urandom_range(2, 918)));
    chk("rd_count", 0, 32'(rd_cnt), 32'd896);
    chk("wr_count", 0, 32'(wr_cnt), 32'd896);
    chk("done_count", 0, 32'(done_cnt), 32'd1);
    chk("done_cycle", 0, 32'(done_at), 32'd918);
    chk("busy_919", 919, {31'd0, o_busy[919]}, 32'd0);
    chk("stage_edge", 131, {28'd0, o_wr[131], o_rd[131], o_wr[132], o_rd[132]},
        32'b1001);
    for (int i = 0; i < 6; i++)
      chk("table", tbl[i].cyc,
          {o_rd[tbl[i].cyc], o_j[tbl[i].cyc], o_jl[tbl[i].cyc], o_k[tbl[i].cyc]},
          {1'b1, 8'(tbl[i].j), 8'(tbl[i].jl), 7'(tbl[i].k)});
    chk("last_stage", 787, {28'd0, o_last[787], o_last[788], o_last[915], o_last[916]},
        32'b0110);

    // start held high: restart the cycle IDLE is re-entered
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 921; c++) begin
      @(negedge clk);
      if (c == 918) chk("held_done", c, {30'd0, done, busy}, 32'b11);
      if (c == 919) chk("held_idle", c, {30'd0, done, busy}, 32'b00);
      if (c == 920)
        chk("held_restart", c, {8'd0, busy, rd_en, rd_addr_j, rd_addr_jl, zeta_idx},
            {8'd0, 1'b1, 1'b1, 8'd0, 8'd2, 7'd127});
    end
    start = 1'b0;

    // reset in mid-run at cycle 300
    rst_n = 1'b0;
    #1;
    check_idle(1, "held_abort");
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 300; c++) @(negedge clk);
    start = 1'b0;
    chk("pre_reset_wr", 300, {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 300,
        {busy, cal_en, done, rd_en, last_stage, wr_en, wr_addr_j, wr_addr_jl,
         rd_addr_j, 2'd0},
        32'd0);
    check_idle(2, "in_reset");
    rst_n = 1'b1;
    check_idle(20, "idle_after_release");

    run(930, int'($urandom_range(2, 918)), int'($urandom_range(2, 918)),
        int'($urandom_range(2, 918)));
    chk("rerun_rd_count", 0, 32'(rd_cnt), 32'd896);
    chk("rerun_wr_count", 0, 32'(wr_cnt), 32'd896);
    chk("rerun_done", 0, 32'(done_at), 32'd918);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
